// File: rtl/timer_controller.sv
// MM:SS countdown sequencer: button edge detection, one-second prescaler and
// IDLE/EDIT/RUN/PAUSE/ALARM control of an external chain of digit timers.

module timer_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 1'b0;
    else        hist <= level;
  end

  assign rise = level & ~hist;
endmodule

module timer_controller #(
  parameter int TICK_DIV = 50000000,
  parameter int PS_W     = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [15:0] digit_value,
  input  logic [3:0]  digits_done,
  output logic        dig_enable,
  output logic        dig_step,
  output logic [3:0]  dig_set,
  output logic [3:0]  dig_set_value,
  output logic [1:0]  sel_digit,
  output logic [2:0]  state,
  output logic        alarm,
  output logic        blink
);
  localparam int NUM_BTN = 3;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [3:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EDIT  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  state_t             st_q, st_nx;
  logic [PS_W-1:0]    ps_q, ps_nx, ps_adv;
  logic [1:0]         sel_q, sel_nx;
  logic               step_nx, blink_nx;
  logic [3:0]         set_nx, setv_nx;
  logic [3:0]         cur_dig;
  logic               wrap, all_zero, counting;
  logic               ev_start, ev_mode, ev_inc;
  logic [NUM_BTN-1:0] btn_lvl, btn_rise;

  // bit 0 = start, 1 = mode, 2 = inc
  assign btn_lvl = {btn_inc, btn_mode, btn_start};

  timer_btn_edge u_edge [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .level (btn_lvl),
    .rise  (btn_rise)
  );

  assign ev_start = btn_rise[0];
  assign ev_mode  = btn_rise[1] & ~btn_rise[0];
  assign ev_inc   = btn_rise[2] & ~btn_rise[1] & ~btn_rise[0];

  assign all_zero = &digits_done;
  assign wrap     = (ps_q == PS_LAST);
  assign ps_adv   = wrap ? '0 : ps_q + PS_W'(1);
  assign cur_dig  = digit_value[{sel_q, 2'b00} +: 4];

  always_comb begin
    st_nx   = st_q;
    sel_nx  = sel_q;
    step_nx = 1'b0;
    set_nx  = '0;
    setv_nx = '0;
    case (st_q)
      S_IDLE: begin
        if (ev_start) begin
          if (!all_zero) st_nx = S_RUN;
        end else if (ev_mode) begin
          st_nx  = S_EDIT;
          sel_nx = 2'd3;
        end
      end
      S_EDIT: begin
        if (ev_start) begin
          st_nx = all_zero ? S_IDLE : S_RUN;
        end else if (ev_mode) begin
          if (sel_q == 2'd0) st_nx = S_IDLE;
          else               sel_nx = sel_q - 2'd1;
        end else if (ev_inc) begin
          set_nx[sel_q] = 1'b1;
          setv_nx = (cur_dig >= DIG_MAX[sel_q]) ? 4'd0 : cur_dig + 4'd1;
        end
      end
      S_RUN: begin
        // start wins over a coincident wrap so a pause never emits a step
        if (ev_start) begin
          st_nx = S_PAUSE;
        end else if (wrap) begin
          if (all_zero) st_nx = S_ALARM;
          else          step_nx = 1'b1;
        end
      end
      S_PAUSE: begin
        if (ev_start)     st_nx = S_RUN;
        else if (ev_mode) st_nx = S_IDLE;
      end
      S_ALARM: begin
        if (ev_start | ev_mode | ev_inc) st_nx = S_IDLE;
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // Prescaler: frozen in PAUSE and IDLE, restarted on fresh entry to RUN/EDIT
  always_comb begin
    counting = (st_q == S_EDIT) || (st_q == S_ALARM) || ((st_q == S_RUN) && !ev_start);
    ps_nx    = counting ? ps_adv : ps_q;
    if (st_nx == S_IDLE)
      ps_nx = '0;
    else if ((st_nx != st_q) && (st_q != S_PAUSE) && ((st_nx == S_RUN) || (st_nx == S_EDIT)))
      ps_nx = '0;
  end

  always_comb begin
    blink_nx = 1'b0;
    if ((st_nx == S_EDIT) || (st_nx == S_ALARM))
      blink_nx = blink ^ (wrap && ((st_q == S_EDIT) || (st_q == S_ALARM)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q          <= S_IDLE;
      ps_q          <= '0;
      sel_q         <= '0;
      dig_enable    <= 1'b0;
      dig_step      <= 1'b0;
      dig_set       <= '0;
      dig_set_value <= '0;
      alarm         <= 1'b0;
      blink         <= 1'b0;
    end else begin
      st_q          <= st_nx;
      ps_q          <= ps_nx;
      sel_q         <= sel_nx;
      dig_enable    <= (st_nx == S_RUN);
      dig_step      <= step_nx;
      dig_set       <= set_nx;
      dig_set_value <= setv_nx;
      alarm         <= (st_nx == S_ALARM);
      blink         <= blink_nx;
    end
  end

  assign state     = st_q;
  assign sel_digit = sel_q;
endmodule
